// File: rtl/tmp_alert_pkg.sv
// Shared encodings and helpers for the multichannel temperature alert block:
// alert FSM states, fault-queue depth decode and resolution masking.
package tmp_alert_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_TRIP_HI = 2'd1,
        ST_WAIT_LO = 2'd2,
        ST_TRIP_LO = 2'd3
    } alert_state_e;

    localparam logic MODE_CMP = 1'b0;
    localparam logic MODE_INT = 1'b1;
    localparam logic POL_LOW  = 1'b0;
    localparam logic POL_HIGH = 1'b1;

    localparam int MAX_TEMP_W = 12;

    function automatic logic [2:0] fault_depth(input logic [1:0] f);
        case (f)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b10:   return 3'd4;
            default: return 3'd6;
        endcase
    endfunction

    // Keeps (9 + r) MSBs of a temp_w-bit sample; narrow inputs are never over-masked.
    function automatic logic [MAX_TEMP_W-1:0] res_mask(input int temp_w, input logic [1:0] r);
        int n;
        n = temp_w - 9 - int'(r);
        if (n < 0) n = 0;
        return {MAX_TEMP_W{1'b1}} << n;
    endfunction

endpackage

// File: rtl/tmp_alert_channel.sv
// One temperature channel: resolution masking, signed threshold compare,
// fault queue, comparator/interrupt alert FSM and saturating over-temp counter.
module tmp_alert_channel
    import tmp_alert_pkg::*;
#(
    parameter int TEMP_W = 12,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tick_i,
    input  logic              ack_i,
    input  logic              clr_i,
    input  logic              tm_i,
    input  logic [1:0]        f_i,
    input  logic [1:0]        r_i,
    input  logic [TEMP_W-1:0] temp_i,
    input  logic [TEMP_W-1:0] t_high_i,
    input  logic [TEMP_W-1:0] t_low_i,
    output logic [TEMP_W-1:0] result_o,
    output logic              alert_o,
    output logic [CNT_W-1:0]  count_o
);

    alert_state_e          state_q, state_d, trip_st;
    logic [2:0]            fc_q, fc_d, fc_inc, depth;
    logic [MAX_TEMP_W-1:0] mask;
    logic [TEMP_W-1:0]     sample, result_q;
    logic [CNT_W-1:0]      count_q;
    logic                  hi, lo, watch, qual;

    assign mask   = res_mask(TEMP_W, r_i);
    assign sample = temp_i & mask[TEMP_W-1:0];
    assign hi     = $signed(sample) >= $signed(t_high_i);
    assign lo     = $signed(sample) <  $signed(t_low_i);
    assign depth  = fault_depth(f_i);
    assign fc_inc = fc_q + 3'd1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_NORMAL;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
        end
    end

    // watch marks states that advance on a run of qualifying samples;
    // interrupt-mode trip states only leave on an acknowledge.
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        trip_st = state_q;
        watch   = 1'b0;
        qual    = 1'b0;
        case (state_q)
            ST_NORMAL: begin
                watch   = 1'b1;
                qual    = hi;
                trip_st = ST_TRIP_HI;
            end
            ST_TRIP_HI: begin
                if (tm_i == MODE_CMP) begin
                    watch   = 1'b1;
                    qual    = lo;
                    trip_st = ST_NORMAL;
                end else if (ack_i) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                watch   = 1'b1;
                qual    = lo;
                trip_st = ST_TRIP_LO;
            end
            ST_TRIP_LO: begin
                if (tm_i == MODE_INT && ack_i) state_d = ST_NORMAL;
            end
            default: state_d = ST_NORMAL;
        endcase
        if (tick_i && watch) begin
            if (!qual) begin
                fc_d = '0;
            end else if (fc_inc >= depth) begin
                state_d = trip_st;
                fc_d    = '0;
            end else begin
                fc_d = fc_inc;
            end
        end
        if (clr_i) begin
            state_d = ST_NORMAL;
            fc_d    = '0;
        end
    end

    always_comb begin
        alert_o = (state_q == ST_TRIP_HI) || (state_q == ST_TRIP_LO);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
            count_q  <= '0;
        end else if (tick_i) begin
            result_q <= sample;
            if (hi && count_q != {CNT_W{1'b1}}) count_q <= count_q + 1'b1;
        end
    end

    assign result_o = result_q;
    assign count_o  = count_q;

endmodule

// File: rtl/tmp_alert_multichannel.sv
// N-channel temperature alert core: conversion timer (continuous / one-shot),
// per-channel alert slices, read-select mux, acknowledge demux and Alert pin.
module tmp_alert_multichannel
    import tmp_alert_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int TEMP_W      = 12,
    parameter int CNT_W       = 8,
    parameter int CONV_CYCLES = 8
) (
    input  logic                                Clk,
    input  logic                                RST,
    input  logic [N_CH*TEMP_W-1:0]              Temp_In,
    input  logic [TEMP_W-1:0]                   T_High,
    input  logic [TEMP_W-1:0]                   T_Low,
    input  logic                                Cfg_OS,
    input  logic [1:0]                          Cfg_R,
    input  logic [1:0]                          Cfg_F,
    input  logic                                Cfg_POL,
    input  logic                                Cfg_TM,
    input  logic                                Cfg_SD,
    input  logic [$clog2(N_CH > 1 ? N_CH : 2)-1:0] Rd_Sel,
    input  logic                                Rd_Ack,
    output logic [15:0]                         Data,
    output logic [N_CH-1:0]                     Alert_Vec,
    output logic                                Alert,
    output logic [N_CH*CNT_W-1:0]               Alert_Count,
    output logic                                Conv_Done,
    output logic                                Busy
);

    localparam int            CW       = $clog2(CONV_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(CONV_CYCLES - 1);

    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          busy_q, busy_d, tick;
    logic                          done_q, alert_q;
    logic                          tm_q;
    logic [1:0]                    f_q;
    logic                          clr;
    logic [N_CH-1:0]               ack_vec, alert_vec;
    logic [N_CH-1:0][TEMP_W-1:0]   results;

    // In shutdown the counter times a pending one-shot instead of free-running;
    // leaving shutdown abandons any pending one-shot and restarts the period.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        tick   = 1'b0;
        if (!Cfg_SD) begin
            if (busy_q) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (busy_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                busy_d = 1'b0;
                tick   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d  = '0;
            busy_d = Cfg_OS;
        end
    end

    assign clr = (Cfg_TM != tm_q) || (Cfg_F != f_q);

    always_ff @(posedge Clk or negedge RST) begin
        if (!RST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            alert_q <= 1'b1;
            tm_q    <= 1'b0;
            f_q     <= 2'b00;
        end else begin
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= tick;
            alert_q <= (Cfg_POL == POL_HIGH) ? |alert_vec : ~|alert_vec;
            tm_q    <= Cfg_TM;
            f_q     <= Cfg_F;
        end
    end

    always_comb begin
        ack_vec = '0;
        if (Rd_Ack && int'(Rd_Sel) < N_CH) ack_vec[Rd_Sel] = 1'b1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tmp_alert_channel #(
            .TEMP_W (TEMP_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk_i    (Clk),
            .rst_ni   (RST),
            .tick_i   (tick),
            .ack_i    (ack_vec[i]),
            .clr_i    (clr),
            .tm_i     (Cfg_TM),
            .f_i      (Cfg_F),
            .r_i      (Cfg_R),
            .temp_i   (Temp_In[i*TEMP_W +: TEMP_W]),
            .t_high_i (T_High),
            .t_low_i  (T_Low),
            .result_o (results[i]),
            .alert_o  (alert_vec[i]),
            .count_o  (Alert_Count[i*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        Data = '0;
        if (int'(Rd_Sel) < N_CH) Data = {results[Rd_Sel], {(16-TEMP_W){1'b0}}};
    end

    assign Alert_Vec = alert_vec;
    assign Alert     = alert_q;
    assign Conv_Done = done_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_tmp_alert_multichannel.sv
// Directed scenarios plus randomized traffic for tmp_alert_multichannel, checked
// every cycle against a behavioural model of the conversion and alert rules.
module tb_tmp_alert_multichannel;

    localparam int N_CH = 4, TEMP_W = 12, CNT_W = 8, CONV_CYCLES = 8;

    logic                     Clk = 1'b0;
    logic                     RST = 1'b0;
    logic [N_CH*TEMP_W-1:0]   Temp_In;
    logic [TEMP_W-1:0]        T_High, T_Low;
    logic                     Cfg_OS, Cfg_POL, Cfg_TM, Cfg_SD, Rd_Ack;
    logic [1:0]               Cfg_R, Cfg_F, Rd_Sel;
    logic [15:0]              Data;
    logic [N_CH-1:0]          Alert_Vec;
    logic                     Alert, Conv_Done, Busy;
    logic [N_CH*CNT_W-1:0]    Alert_Count;

    logic [TEMP_W-1:0]        temp [N_CH];

    always #5 Clk = ~Clk;

    always_comb begin
        Temp_In = '0;
        for (int i = 0; i < N_CH; i++) Temp_In[i*TEMP_W +: TEMP_W] = temp[i];
    end

    tmp_alert_multichannel #(
        .N_CH(N_CH), .TEMP_W(TEMP_W), .CNT_W(CNT_W), .CONV_CYCLES(CONV_CYCLES)
    ) dut (
        .Clk(Clk), .RST(RST), .Temp_In(Temp_In), .T_High(T_High), .T_Low(T_Low),
        .Cfg_OS(Cfg_OS), .Cfg_R(Cfg_R), .Cfg_F(Cfg_F), .Cfg_POL(Cfg_POL), .Cfg_TM(Cfg_TM),
        .Cfg_SD(Cfg_SD), .Rd_Sel(Rd_Sel), .Rd_Ack(Rd_Ack), .Data(Data), .Alert_Vec(Alert_Vec),
        .Alert(Alert), .Alert_Count(Alert_Count), .Conv_Done(Conv_Done), .Busy(Busy)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: age counts edges since the period/one-shot started,
    // each channel is {alerting, low-phase} plus a run length of qualifying samples.
    int                age_m, ntick;
    bit                busy_m, done_m, alert_m;
    logic [TEMP_W-1:0] res_m    [N_CH];
    int                cnt_m    [N_CH];
    bit                trip_m   [N_CH];
    bit                lophase_m[N_CH];
    int                run_m    [N_CH];
    logic              prev_tm;
    logic [1:0]        prev_f;

    task automatic model_reset();
        age_m = 0; ntick = 0; busy_m = 0; done_m = 0; alert_m = 1;
        prev_tm = 0; prev_f = 0;
        for (int c = 0; c < N_CH; c++) begin
            res_m[c] = '0; cnt_m[c] = 0; trip_m[c] = 0; lophase_m[c] = 0; run_m[c] = 0;
        end
    endtask

    task automatic model_step();
        bit tk, clr, any, hi, lo, ack, want;
        int need;
        logic [TEMP_W-1:0] s;
        any = 0;
        for (int c = 0; c < N_CH; c++) any |= trip_m[c];
        alert_m = Cfg_POL ? any : !any;
        tk = 0;
        if (!Cfg_SD) begin
            if (busy_m) begin
                busy_m = 0; age_m = 0;
            end else begin
                age_m++;
                if (age_m == CONV_CYCLES) begin age_m = 0; tk = 1; end
            end
        end else if (busy_m) begin
            age_m++;
            if (age_m == CONV_CYCLES) begin age_m = 0; tk = 1; busy_m = 0; end
        end else begin
            age_m = 0;
            busy_m = Cfg_OS;
        end
        clr = (Cfg_TM != prev_tm) || (Cfg_F != prev_f);
        prev_tm = Cfg_TM; prev_f = Cfg_F;
        need = (Cfg_F == 2'd0) ? 1 : (Cfg_F == 2'd1) ? 2 : (Cfg_F == 2'd2) ? 4 : 6;
        for (int c = 0; c < N_CH; c++) begin
            s   = temp[c] & (12'hFFF << (3 - int'(Cfg_R)));
            hi  = $signed(s) >= $signed(T_High);
            lo  = $signed(s) <  $signed(T_Low);
            ack = Rd_Ack && (int'(Rd_Sel) == c);
            if (tk) begin
                res_m[c] = s;
                if (hi && cnt_m[c] < 255) cnt_m[c]++;
            end
            if (clr) begin
                trip_m[c] = 0; lophase_m[c] = 0; run_m[c] = 0;
            end else if (Cfg_TM && trip_m[c]) begin
                if (ack) begin
                    trip_m[c] = 0; lophase_m[c] = !lophase_m[c]; run_m[c] = 0;
                end
            end else if (tk) begin
                want = (trip_m[c] || lophase_m[c]) ? lo : hi;
                if (!want) run_m[c] = 0;
                else if (run_m[c] + 1 >= need) begin trip_m[c] = !trip_m[c]; run_m[c] = 0; end
                else run_m[c]++;
            end
        end
        done_m = tk;
        if (tk) ntick++;
    endtask

    task automatic check_model();
        logic [N_CH-1:0]       av;
        logic [N_CH*CNT_W-1:0] ac;
        logic [15:0]           d;
        for (int c = 0; c < N_CH; c++) begin
            av[c] = trip_m[c];
            ac[c*CNT_W +: CNT_W] = CNT_W'(cnt_m[c]);
        end
        d = {res_m[Rd_Sel], 4'h0};
        chk("alert_vec", Alert_Vec, av);
        chk("alert", Alert, alert_m);
        chk("conv_done", Conv_Done, done_m);
        chk("busy", Busy, busy_m);
        chk("data", Data, d);
        chk("alert_count", Alert_Count, ac);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge Clk);
            if (RST) model_step();
            @(negedge Clk);
            check_model();
        end
    endtask

    task automatic wait_tick(input int k);
        for (int j = 0; j < k; j++) begin
            int t0, lim;
            t0 = ntick; lim = 0;
            while (ntick == t0 && lim < 40) begin cyc(1); lim++; end
            if (ntick == t0) chk("tick_timeout", ntick, t0 + 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, first, lim;
        for (int c = 0; c < N_CH; c++) temp[c] = '0;
        T_High = 12'h400; T_Low = 12'h300;
        Cfg_OS = 0; Cfg_R = 2'b11; Cfg_F = 2'b00; Cfg_POL = 0; Cfg_TM = 0; Cfg_SD = 0;
        Rd_Sel = 0; Rd_Ack = 0;
        model_reset();
        #23;
        chk("rst_alert", Alert, 1'b1);
        chk("rst_data", Data, 16'h0);
        chk("rst_vec", Alert_Vec, 4'h0);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Conv_Done, 1'b0);
        @(negedge Clk); RST = 1;

        // comparator mode, fault queue of 2
        Cfg_F = 2'b01; cyc(1);
        temp[0] = 12'h500;
        wait_tick(1); chk("cmp_f2_first", Alert_Vec[0], 1'b0);
        wait_tick(1); chk("cmp_f2_trip", Alert_Vec[0], 1'b1); chk("cmp_alert_lag", Alert, 1'b1);
        cyc(1);       chk("cmp_alert_low", Alert, 1'b0);
        temp[0] = 12'h200;
        wait_tick(1); chk("cmp_clr_first", Alert_Vec[0], 1'b1);
        wait_tick(1); chk("cmp_clr", Alert_Vec[0], 1'b0);

        // interrupt mode, fault queue of 1
        Cfg_TM = 1; Cfg_F = 2'b00; cyc(1);
        temp[1] = 12'h500;
        wait_tick(1); chk("int_trip_hi", Alert_Vec[1], 1'b1);
        Rd_Sel = 1; Rd_Ack = 1; cyc(1); Rd_Ack = 0;
        chk("int_ack_hi", Alert_Vec[1], 1'b0);
        temp[1] = 12'h200;
        wait_tick(1); chk("int_trip_lo", Alert_Vec[1], 1'b1);
        Rd_Ack = 1; cyc(1); Rd_Ack = 0;
        chk("int_ack_lo", Alert_Vec[1], 1'b0);
        wait_tick(1); chk("int_normal", Alert_Vec[1], 1'b0);

        // resolution masking and signed compare
        Cfg_TM = 0; cyc(1);
        Cfg_R = 2'b00; temp[2] = 12'h7FF; Rd_Sel = 2;
        wait_tick(1); chk("res9_data", Data, 16'h7F80);
        Cfg_R = 2'b11;
        wait_tick(1); chk("res12_data", Data, 16'h7FF0);
        T_High = 12'h000; T_Low = 12'h000; temp[2] = 12'h800;
        wait_tick(2); chk("neg_no_alert", Alert_Vec[2], 1'b0);

        // shutdown and one-shot
        Cfg_SD = 1; nd = 0;
        for (int i = 0; i < 100; i++) begin cyc(1); nd += int'(Conv_Done); end
        chk("sd_no_done", nd, 0);
        Cfg_OS = 1; cyc(1); Cfg_OS = 0;
        chk("os_busy", Busy, 1'b1);
        nd = 0; first = -1;
        for (int j = 1; j <= 20; j++) begin
            cyc(1);
            if (Conv_Done) begin nd++; if (first < 0) first = j; end
        end
        chk("os_done_at", first, 8);
        chk("os_done_n", nd, 1);
        chk("os_busy_end", Busy, 1'b0);

        // counter saturation, then ack racing a trip tick
        Cfg_SD = 0; T_High = 12'h400; T_Low = 12'h300; temp[3] = 12'h500; Rd_Sel = 3;
        wait_tick(300);
        chk("cnt_sat", Alert_Count[3*CNT_W +: CNT_W], 8'd255);
        Cfg_TM = 1; temp[3] = 12'h000; cyc(2);
        lim = 0;
        while (age_m != CONV_CYCLES - 1 && lim < 20) begin cyc(1); lim++; end
        chk("pre_tick_found", age_m, CONV_CYCLES - 1);
        temp[3] = 12'h500; Rd_Ack = 1; cyc(1); Rd_Ack = 0;
        chk("ack_vs_trip", Alert_Vec[3], 1'b1);

        // asynchronous reset while alerting
        Cfg_TM = 0; cyc(1);
        temp[0] = 12'h500; Rd_Sel = 0;
        wait_tick(1); chk("pre_rst_trip", Alert_Vec[0], 1'b1);
        cyc(2);
        #2 RST = 0; model_reset();
        #1;
        chk("arst_data", Data, 16'h0);
        chk("arst_vec", Alert_Vec, 4'h0);
        chk("arst_alert", Alert, 1'b1);
        chk("arst_cnt", Alert_Count, 32'h0);
        @(negedge Clk); RST = 1;

        // randomized traffic around the thresholds
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N_CH; c++)
                if ($urandom_range(0, 7) == 0)
                    temp[c] = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(12'h2E0, 12'h420));
            Rd_Sel = 2'($urandom);
            Rd_Ack = ($urandom_range(0, 9) == 0);
            Cfg_OS = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 99) == 0)  Cfg_SD  = !Cfg_SD;
            if ($urandom_range(0, 199) == 0) Cfg_TM  = !Cfg_TM;
            if ($urandom_range(0, 199) == 0) Cfg_F   = 2'($urandom);
            if ($urandom_range(0, 99) == 0)  Cfg_R   = 2'($urandom);
            if ($urandom_range(0, 149) == 0) Cfg_POL = !Cfg_POL;
            cyc(1);
        end
        Rd_Ack = 0; Cfg_OS = 0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
